pwm_led_sched: RTL and testbench
================================

Name: pwm_led_sched

Overview:
- Time-slice scheduler that shares one breathing-LED PWM channel between N status requesters.
- Each requester asks for the channel with its own speed-divider value.
- Arbitration is round-robin. Each winner holds the channel for a fixed number of breathe periods.
- Before every hand-over, the scheduler commands a fade-out, so the LED never jumps in brightness. Sits between status sources and the PWM breathing generator.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SPEED_W, 11, width of one speed-divider value.
- SLICE_PERIODS, 2, breathe periods a winner keeps the channel while others wait (1..15).
- STARTUP_CYCLES, 256, clock cycles after reset release before the first grant (brownout settle).

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  reset
- i_req  input  N_REQ  level request per requester
- i_speed  input  N_REQ*SPEED_W  packed speed values; requester k at bits [k*SPEED_W +: SPEED_W]
- i_period_done  input  1  one-cycle pulse from PWM: one full breathe period finished
- i_duty_zero  input  1  level from PWM: current duty is 0
- o_grant  output  N_REQ  one-hot current owner; 0 when none
- o_en  output  1  PWM enable
- o_fade_out  output  1  PWM instruction to ramp duty down and hold at 0
- o_speed  output  SPEED_W  speed divider forwarded to PWM
- o_busy  output  1  state != IDLE

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0, state IDLE, startup counter 0, slice counter 0, round-robin pointer = N_REQ-1 (so requester 0 is first).
- Startup: counter increments each cycle after i_rstn deasserts and saturates at STARTUP_CYCLES. Grants are blocked until saturation.
- IDLE:
  - o_en=0.
  - If startup is done and any i_req is set, go to ARB on the next edge.
- ARB (exactly 1 cycle):
  - Pick the first set i_req scanning from pointer+1 upward, with wrap.
  - Register o_grant and latch o_speed from the winner's slice of i_speed.
  - Pointer = winner; slice counter = 0; go to RUN.
  - If all requests have dropped, return to IDLE with no grant.
- RUN:
  - o_en=1, o_fade_out=0.
  - Each i_period_done increments the slice counter, saturating at SLICE_PERIODS.
  - Go to DRAIN when either:
    - the winner's i_req is 0, or
    - slice count == SLICE_PERIODS and another requester is pending.
  - If no other requester is pending, the winner keeps the channel indefinitely.
  - o_speed stays frozen while in RUN; i_speed changes are ignored until the next ARB.
- DRAIN:
  - o_en=1, o_fade_out=1, o_grant unchanged.
  - When i_duty_zero=1: o_grant clears and o_fade_out clears. Go to ARB if any i_req is set, else IDLE.
  - The winner dropping or re-raising its request during DRAIN does not abort the drain.
- Simultaneous events:
  - i_period_done in the same cycle the winner drops: the drop wins; go to DRAIN and still count the period.
  - i_duty_zero already 1 on DRAIN entry: leave after 1 cycle.
- Round-robin ordering: the pointer advances only on a successful grant. A single requester is re-granted through ARB after its own drain.
- Reset mid-operation: asynchronous return to the reset values above, including restart of the startup wait.
- Latency: a request raised in IDLE with startup done gives o_grant/o_en at the 2nd rising edge after i_req is sampled (IDLE->ARB->RUN). o_grant is registered in ARB; o_en asserts on RUN entry.

Optional Feature:
- Macro: PWM_LED_SCHED_PRIO0_EN.
- Defined:
  - Requester 0 is urgent. A rising i_req[0] while another requester is in RUN forces DRAIN immediately, regardless of the slice count.
  - ARB picks requester 0 whenever it is set, ignoring the pointer.
  - While requester 0 owns the channel, other requests never cause it to leave before SLICE_PERIODS.
- Undefined: pure round-robin as above; requester 0 has no special status.

Test Plan:
1. Startup gate: reset, hold i_req=4'b0010 from cycle 0, speed1=124 -> o_grant stays 0 until STARTUP_CYCLES+1; then o_grant=4'b0010, o_speed=124, o_en=1 at STARTUP_CYCLES+2.
2. Round-robin slices: i_req=4'b1011, 2 i_period_done pulses per owner, i_duty_zero asserted 5 cycles into each DRAIN -> grant order 0001, 0010, 1000, 0001; o_fade_out high only in DRAIN.
3. Lone requester: i_req=4'b0100, 10 period pulses -> o_grant stays 4'b0100, never enters DRAIN; drop i_req -> DRAIN, then IDLE after i_duty_zero, o_busy=0.
4. Drop and period together: in RUN, drop the winner's req in the same cycle as i_period_done -> next state DRAIN, slice count incremented, no assertion failures.
5. Async reset mid-DRAIN: pull i_rstn low between edges -> all outputs 0 immediately; on release, the startup wait repeats (no grant before STARTUP_CYCLES).
6. PWM_LED_SCHED_PRIO0_EN defined: requester 2 in RUN with slice count 0, raise i_req[0] -> DRAIN on the next edge; after i_duty_zero, o_grant=4'b0001 even though the pointer favours 3.

Source files
------------

// File: rtl/pwm_led_sched.sv
// Round-robin time-slice scheduler sharing one breathing-LED PWM channel among N_REQ requesters.
// Optional urgent requester 0 behaviour is enabled by defining PWM_LED_SCHED_PRIO0_EN.
module pwm_led_sched #(
  parameter int N_REQ          = 4,
  parameter int SPEED_W        = 11,
  parameter int SLICE_PERIODS  = 2,
  parameter int STARTUP_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*SPEED_W-1:0] i_speed,
  input  logic                     i_period_done,
  input  logic                     i_duty_zero,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_en,
  output logic                     o_fade_out,
  output logic [SPEED_W-1:0]       o_speed,
  output logic                     o_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STW   = $clog2(STARTUP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARB, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [STW-1:0]     start_q, start_d;
  logic [3:0]         slice_q, slice_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  logic               startup_done;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [N_REQ-1:0]   pick_oh;
  logic [SPEED_W-1:0] pick_speed;
  logic               owner_req;
  logic               others_req;
  logic               slice_full;
  logic               urgent;

  assign startup_done = (start_q == STW'(STARTUP_CYCLES));
  assign owner_req    = |(i_req & grant_q);
  assign others_req   = |(i_req & ~grant_q);
  assign slice_full   = (slice_q == 4'(SLICE_PERIODS));

`ifdef PWM_LED_SCHED_PRIO0_EN
  logic req0_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) req0_q <= 1'b0;
    else         req0_q <= i_req[0];
  end

  // Only a fresh request from requester 0 preempts a different owner.
  assign urgent = i_req[0] & ~req0_q & ~grant_q[0];
`else
  assign urgent = 1'b0;
`endif

  // Scan from the requester after the last winner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    pick_oh    = '0;
    pick_speed = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = PTR_W'((int'(ptr_q) + 1 + j) % N_REQ);
      if (!pick_valid && i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef PWM_LED_SCHED_PRIO0_EN
    if (i_req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_valid && pick_idx == PTR_W'(k)) begin
        pick_oh[k] = 1'b1;
        pick_speed = i_speed[k*SPEED_W +: SPEED_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = startup_done ? start_q : start_q + STW'(1);
    slice_d = slice_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    speed_d = speed_q;
    case (state_q)
      IDLE: begin
        if (startup_done && |i_req) state_d = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          speed_d = pick_speed;
          ptr_d   = pick_idx;
          slice_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (i_period_done && !slice_full) slice_d = slice_q + 4'd1;
        // A drop always wins over a simultaneous period pulse, which is still counted.
        if (!owner_req || (slice_full && others_req) || urgent) state_d = DRAIN;
      end
      DRAIN: begin
        if (i_duty_zero) begin
          grant_d = '0;
          state_d = (|i_req) ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      start_q <= '0;
      slice_q <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      grant_q <= '0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      slice_q <= slice_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      speed_q <= speed_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_speed    = speed_q;
  assign o_en       = (state_q == RUN) || (state_q == DRAIN);
  assign o_fade_out = (state_q == DRAIN);
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_led_sched.sv
// Self-checking bench for pwm_led_sched: directed sequences, a vector table and a
// randomized run checked against an arbitration model; honours PWM_LED_SCHED_PRIO0_EN.
module tb_pwm_led_sched;
  localparam int N     = 4;
  localparam int SW    = 11;
  localparam int START = 256;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*SW-1:0] speed;
  logic            pd, dz;
  logic [N-1:0]    o_grant;
  logic            o_en, o_fade_out, o_busy;
  logic [SW-1:0]   o_speed;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [N-1:0]  req;
    logic          pd;
    logic          dz;
    logic [N-1:0]  grant;
    logic          en;
    logic          fade;
    logic          busy;
    logic [SW-1:0] spd;
  } vec_t;

  vec_t vecs[19];

`ifdef PWM_LED_SCHED_PRIO0_EN
  localparam logic [N-1:0]  G13 = 4'b0001;
  localparam logic [SW-1:0] S13 = 11'd100;
`else
  localparam logic [N-1:0]  G13 = 4'b1000;
  localparam logic [SW-1:0] S13 = 11'd103;
`endif

  always #5 clk = ~clk;

  pwm_led_sched #(.N_REQ(N), .SPEED_W(SW), .SLICE_PERIODS(2), .STARTUP_CYCLES(START)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_speed(speed),
    .i_period_done(pd), .i_duty_zero(dz),
    .o_grant(o_grant), .o_en(o_en), .o_fade_out(o_fade_out),
    .o_speed(o_speed), .o_busy(o_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic p, input logic d);
    req = r;
    pd  = p;
    dz  = d;
  endtask

  task automatic setSpeed(input int k, input logic [SW-1:0] v);
    speed[k*SW +: SW] = v;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
    step(2);
    rstn = 1'b1;
  endtask

  function automatic bit cond(input int which);
    if (which == 0) return (o_grant != '0);
    return (o_fade_out == 1'b1);
  endfunction

  task automatic waitFor(input string name, input int which, input int limit);
    int n;
    n = 0;
    while (!cond(which) && n < limit) begin
      step(1);
      n++;
    end
    if (!cond(which)) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic vec_t mk(input logic [N-1:0] r, input logic p, input logic d,
                              input logic [N-1:0] g, input logic e, input logic f,
                              input logic b, input logic [SW-1:0] s);
    vec_t v;
    v.req = r; v.pd = p; v.dz = d; v.grant = g;
    v.en = e; v.fade = f; v.busy = b; v.spd = s;
    return v;
  endfunction

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0]  expOrder[4];
    logic [N-1:0]  r, expG, prevGrant;
    logic [SW-1:0] expS;
    logic          prevEn;
    int            ptrM, expIdx, k;
    bit            pending;

    vecs[0]  = mk(4'b0100, 0, 0, 4'b0000, 0, 0, 1, 11'd0);
    vecs[1]  = mk(4'b0100, 0, 0, 4'b0100, 1, 0, 1, 11'd102);
    vecs[2]  = mk(4'b0100, 1, 0, 4'b0100, 1, 0, 1, 11'd102);
    vecs[3]  = mk(4'b0100, 1, 0, 4'b0100, 1, 0, 1, 11'd102);
    vecs[4]  = mk(4'b0100, 1, 0, 4'b0100, 1, 0, 1, 11'd102);
    vecs[5]  = mk(4'b0110, 0, 0, 4'b0100, 1, 1, 1, 11'd102);
    vecs[6]  = mk(4'b0110, 0, 0, 4'b0100, 1, 1, 1, 11'd102);
    vecs[7]  = mk(4'b0010, 0, 0, 4'b0100, 1, 1, 1, 11'd102);
    vecs[8]  = mk(4'b0010, 0, 1, 4'b0000, 0, 0, 1, 11'd102);
    vecs[9]  = mk(4'b0010, 0, 0, 4'b0010, 1, 0, 1, 11'd101);
    vecs[10] = mk(4'b0000, 1, 0, 4'b0010, 1, 1, 1, 11'd101);
    vecs[11] = mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 11'd101);
    vecs[12] = mk(4'b1001, 0, 0, 4'b0000, 0, 0, 1, 11'd101);
    vecs[13] = mk(4'b1001, 0, 0, G13,     1, 0, 1, S13);
    vecs[14] = mk(4'b1001, 1, 0, G13,     1, 0, 1, S13);
    vecs[15] = mk(4'b1001, 1, 0, G13,     1, 0, 1, S13);
    vecs[16] = mk(4'b1001, 0, 0, G13,     1, 1, 1, S13);
    vecs[17] = mk(4'b1001, 0, 1, 4'b0000, 0, 0, 1, S13);
    vecs[18] = mk(4'b1001, 0, 0, 4'b0001, 1, 0, 1, 11'd100);

`ifdef PWM_LED_SCHED_PRIO0_EN
    expOrder = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    expOrder = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif

    speed = '0;
    doReset();
    checkOutput("reset_grant", 32'(o_grant), 32'd0);
    checkOutput("reset_en",    32'(o_en), 32'd0);
    checkOutput("reset_fade",  32'(o_fade_out), 32'd0);
    checkOutput("reset_busy",  32'(o_busy), 32'd0);
    checkOutput("reset_speed", 32'(o_speed), 32'd0);

    // Startup gate with a request held from the first cycle.
    setSpeed(1, 11'd124);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    step(START);
    checkOutput("startup_busy_early", 32'(o_busy), 32'd0);
    checkOutput("startup_grant_early", 32'(o_grant), 32'd0);
    step(1);
    checkOutput("startup_arb_busy", 32'(o_busy), 32'd1);
    checkOutput("startup_arb_grant", 32'(o_grant), 32'd0);
    checkOutput("startup_arb_en", 32'(o_en), 32'd0);
    step(1);
    checkOutput("startup_grant", 32'(o_grant), 32'b0010);
    checkOutput("startup_speed", 32'(o_speed), 32'd124);
    checkOutput("startup_en", 32'(o_en), 32'd1);

    // Vector table from a fresh idle state.
    doReset();
    for (int i = 0; i < N; i++) setSpeed(i, SW'(100 + i));
    step(START + 1);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].pd, vecs[i].dz);
      step(1);
      checkOutput($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].grant));
      checkOutput($sformatf("vec%0d_en", i),    32'(o_en), 32'(vecs[i].en));
      checkOutput($sformatf("vec%0d_fade", i),  32'(o_fade_out), 32'(vecs[i].fade));
      checkOutput($sformatf("vec%0d_busy", i),  32'(o_busy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_speed", i), 32'(o_speed), 32'(vecs[i].spd));
    end

    // Round-robin slices with delayed duty-zero in each drain.
    doReset();
    applyStimulus(4'b1011, 1'b0, 1'b0);
    step(START + 1);
    for (int o = 0; o < 4; o++) begin
      waitFor("rr_grant", 0, 20);
      checkOutput($sformatf("rr%0d_grant", o), 32'(o_grant), 32'(expOrder[o]));
      checkOutput($sformatf("rr%0d_fade_run", o), 32'(o_fade_out), 32'd0);
      applyStimulus(4'b1011, 1'b1, 1'b0); step(1);
      applyStimulus(4'b1011, 1'b1, 1'b0); step(1);
      applyStimulus(4'b1011, 1'b0, 1'b0);
      waitFor("rr_drain", 1, 5);
      checkOutput($sformatf("rr%0d_drain_grant", o), 32'(o_grant), 32'(expOrder[o]));
      step(4);
      checkOutput($sformatf("rr%0d_fade_hold", o), 32'(o_fade_out), 32'd1);
      applyStimulus(4'b1011, 1'b0, 1'b1); step(1);
      checkOutput($sformatf("rr%0d_fade_clr", o), 32'(o_fade_out), 32'd0);
      checkOutput($sformatf("rr%0d_grant_clr", o), 32'(o_grant), 32'd0);
      applyStimulus(4'b1011, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a drain.
    waitFor("ar_grant", 0, 5);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);
    checkOutput("ar_in_drain", 32'(o_fade_out), 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("ar_grant", 32'(o_grant), 32'd0);
    checkOutput("ar_en",    32'(o_en), 32'd0);
    checkOutput("ar_fade",  32'(o_fade_out), 32'd0);
    checkOutput("ar_busy",  32'(o_busy), 32'd0);
    checkOutput("ar_speed", 32'(o_speed), 32'd0);
    @(negedge clk);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    rstn = 1'b1;
    step(START);
    checkOutput("ar_restart_busy", 32'(o_busy), 32'd0);
    checkOutput("ar_restart_grant", 32'(o_grant), 32'd0);
    step(2);
    checkOutput("ar_regrant", 32'(o_grant), 32'b0001);

    // Lone requester keeps the channel through many periods.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0); step(1);
      applyStimulus(4'b0001, 1'b0, 1'b0); step(1);
      checkOutput($sformatf("lone%0d_grant", i), 32'(o_grant), 32'b0001);
      checkOutput($sformatf("lone%0d_fade", i), 32'(o_fade_out), 32'd0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0); step(1);
    checkOutput("lone_drain", 32'(o_fade_out), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1); step(1);
    checkOutput("lone_idle_busy", 32'(o_busy), 32'd0);
    checkOutput("lone_idle_grant", 32'(o_grant), 32'd0);

`ifdef PWM_LED_SCHED_PRIO0_EN
    // Urgent requester 0 preempts requester 2 at slice count 0.
    doReset();
    step(START + 1);
    applyStimulus(4'b0100, 1'b0, 1'b0); step(2);
    checkOutput("prio_owner2", 32'(o_grant), 32'b0100);
    applyStimulus(4'b1101, 1'b0, 1'b0); step(1);
    checkOutput("prio_drain", 32'(o_fade_out), 32'd1);
    applyStimulus(4'b1101, 1'b0, 1'b1); step(1);
    applyStimulus(4'b1101, 1'b0, 1'b0); step(1);
    checkOutput("prio_grant0", 32'(o_grant), 32'b0001);
`endif

    // Randomized run against an arbitration model.
    doReset();
    step(START + 1);
    ptrM = N - 1;
    pending = 1'b0;
    prevEn = 1'b0;
    prevGrant = '0;
    expG = '0;
    expS = '0;
    expIdx = -1;
    r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pending) begin
        checkOutput("rand_grant", 32'(o_grant), 32'(expG));
        checkOutput("rand_en", 32'(o_en), 32'(expG != '0));
        if (expG != '0) begin
          checkOutput("rand_speed", 32'(o_speed), 32'(expS));
          ptrM = expIdx;
        end
        pending = 1'b0;
      end else if (prevEn && o_en) begin
        checkOutput("rand_hold", 32'(o_grant), 32'(prevGrant));
      end
      checkOutput("rand_onehot", 32'($onehot0(o_grant)), 32'd1);
      checkOutput("rand_en_owner", 32'(o_en && o_grant == '0), 32'd0);
      checkOutput("rand_fade_en", 32'(o_fade_out && !o_en), 32'd0);
      prevEn = o_en;
      prevGrant = o_grant;

      if ($urandom_range(7) == 0) r = N'($urandom);
      if ($urandom_range(15) == 0) begin
        k = int'($urandom_range(N - 1));
        setSpeed(k, SW'($urandom));
      end
      applyStimulus(r, $urandom_range(5) == 0, $urandom_range(3) == 0);

      if (o_busy && !o_en) begin
        expIdx = -1;
        for (int j = 1; j <= N; j++) begin
          k = (ptrM + j) % N;
          if (expIdx < 0 && req[k]) expIdx = k;
        end
`ifdef PWM_LED_SCHED_PRIO0_EN
        if (req[0]) expIdx = 0;
`endif
        if (expIdx >= 0) begin
          expG = N'(1) << expIdx;
          expS = speed[expIdx*SW +: SW];
        end else begin
          expG = '0;
          expS = '0;
        end
        pending = 1'b1;
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
